// File: rtl/m2_cpu8_pkg.sv
//============================================================================
// Module   : m2_cpu8_pkg
// Brief    : Shared widths, opcodes, micro-op encoding and built-in program
//            for the m2_cpu8 microprogrammed CPU.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

package m2_cpu8_pkg;

    localparam int unsigned M2_ADDR_W = 5;
    localparam int unsigned M2_OPC_W  = 4;
    localparam int unsigned M2_DATA_W = M2_OPC_W + M2_ADDR_W;

    localparam logic [M2_OPC_W-1:0] OPC_LDA = 4'b0000;
    localparam logic [M2_OPC_W-1:0] OPC_ADD = 4'b0001;
    localparam logic [M2_OPC_W-1:0] OPC_SUB = 4'b0010;
    localparam logic [M2_OPC_W-1:0] OPC_OUT = 4'b1110;
    localparam logic [M2_OPC_W-1:0] OPC_HLT = 4'b1111;

    localparam logic [M2_ADDR_W-1:0] MAP_NOP = 5'd0;
    localparam logic [M2_ADDR_W-1:0] MAP_LDA = 5'd4;
    localparam logic [M2_ADDR_W-1:0] MAP_ADD = 5'd6;
    localparam logic [M2_ADDR_W-1:0] MAP_SUB = 5'd9;
    localparam logic [M2_ADDR_W-1:0] MAP_OUT = 5'd12;
    localparam logic [M2_ADDR_W-1:0] MAP_HLT = 5'd13;

    // Vertical micro-word: each encoding expands to a fixed strobe set.
    typedef enum logic [3:0] {
        UOP_FETCH_ADDR = 4'd0,
        UOP_PC_INC     = 4'd1,
        UOP_FETCH_IR   = 4'd2,
        UOP_MAP        = 4'd3,
        UOP_OPER_ADDR  = 4'd4,
        UOP_LDA_EXEC   = 4'd5,
        UOP_LOAD_B     = 4'd6,
        UOP_ADD_EXEC   = 4'd7,
        UOP_SUB_EXEC   = 4'd8,
        UOP_OUT_EXEC   = 4'd9,
        UOP_HALT       = 4'd10,
        UOP_CLR        = 4'd11
    } uop_e;

    typedef struct packed {
        logic ep;
        logic cp;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic cs;
        logic load;
        logic inc;
        logic clr;
        logic la;
        logic ea;
        logic su;
        logic ad;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_t;

    function automatic logic [M2_DATA_W-1:0] ram_word(input logic [M2_ADDR_W-1:0] addr);
        case (addr)
            5'd0:    ram_word = {OPC_LDA, 5'd9};
            5'd1:    ram_word = {OPC_ADD, 5'd10};
            5'd2:    ram_word = {OPC_SUB, 5'd11};
            5'd3:    ram_word = {OPC_OUT, 5'd0};
            5'd4:    ram_word = {OPC_HLT, 5'd0};
            5'd9:    ram_word = 9'd16;
            5'd10:   ram_word = 9'd20;
            5'd11:   ram_word = 9'd6;
            default: ram_word = '0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/m2_cpu8_useq.sv
//============================================================================
// Module   : m2_cpu8_useq
// Brief    : Micro-PC, opcode mapping ROM, control store and strobe decoder.
// Config   : M2_CPU8_HLT_EN makes micro-word 13 a true halt.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module m2_cpu8_useq
    import m2_cpu8_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [M2_OPC_W-1:0]  i_opcode,
    output logic [M2_ADDR_W-1:0] o_pre_out,
    output ctrl_t                o_ctrl
);

    logic [M2_ADDR_W-1:0] upc_q, upc_d;
    uop_e                 uop;

    always_comb begin
        case (i_opcode)
            OPC_LDA: o_pre_out = MAP_LDA;
            OPC_ADD: o_pre_out = MAP_ADD;
            OPC_SUB: o_pre_out = MAP_SUB;
            OPC_OUT: o_pre_out = MAP_OUT;
            OPC_HLT: o_pre_out = MAP_HLT;
            default: o_pre_out = MAP_NOP;
        endcase
    end

    always_comb begin
        case (upc_q)
            5'd0:    uop = UOP_FETCH_ADDR;
            5'd1:    uop = UOP_PC_INC;
            5'd2:    uop = UOP_FETCH_IR;
            5'd3:    uop = UOP_MAP;
            5'd4:    uop = UOP_OPER_ADDR;
            5'd5:    uop = UOP_LDA_EXEC;
            5'd6:    uop = UOP_OPER_ADDR;
            5'd7:    uop = UOP_LOAD_B;
            5'd8:    uop = UOP_ADD_EXEC;
            5'd9:    uop = UOP_OPER_ADDR;
            5'd10:   uop = UOP_LOAD_B;
            5'd11:   uop = UOP_SUB_EXEC;
            5'd12:   uop = UOP_OUT_EXEC;
`ifdef M2_CPU8_HLT_EN
            5'd13:   uop = UOP_HALT;
`endif
            default: uop = UOP_CLR;
        endcase
    end

    always_comb begin
        o_ctrl    = '0;
        o_ctrl.cs = 1'b1;
        case (uop)
            UOP_FETCH_ADDR: begin o_ctrl.ep = 1'b1; o_ctrl.lm = 1'b1; o_ctrl.inc = 1'b1; end
            UOP_PC_INC:     begin o_ctrl.cp = 1'b1; o_ctrl.inc = 1'b1; end
            UOP_FETCH_IR:   begin o_ctrl.ce = 1'b1; o_ctrl.li = 1'b1; o_ctrl.inc = 1'b1; end
            UOP_MAP:        o_ctrl.load = 1'b1;
            UOP_OPER_ADDR:  begin o_ctrl.ei = 1'b1; o_ctrl.lm = 1'b1; o_ctrl.inc = 1'b1; end
            UOP_LDA_EXEC:   begin o_ctrl.ce = 1'b1; o_ctrl.la = 1'b1; o_ctrl.clr = 1'b1; end
            UOP_LOAD_B:     begin o_ctrl.ce = 1'b1; o_ctrl.lb = 1'b1; o_ctrl.inc = 1'b1; end
            UOP_ADD_EXEC:   begin o_ctrl.ad = 1'b1; o_ctrl.eu = 1'b1; o_ctrl.la = 1'b1; o_ctrl.clr = 1'b1; end
            UOP_SUB_EXEC:   begin o_ctrl.su = 1'b1; o_ctrl.eu = 1'b1; o_ctrl.la = 1'b1; o_ctrl.clr = 1'b1; end
            UOP_OUT_EXEC:   begin o_ctrl.ea = 1'b1; o_ctrl.lo = 1'b1; o_ctrl.clr = 1'b1; end
            // No sequencing strobe at all, so the micro-PC parks here until reset.
            UOP_HALT:       o_ctrl.cs = 1'b0;
            UOP_CLR:        o_ctrl.clr = 1'b1;
            default:        o_ctrl.clr = 1'b1;
        endcase
    end

    always_comb begin
        upc_d = upc_q;
        if (o_ctrl.clr)
            upc_d = '0;
        else if (o_ctrl.load)
            upc_d = o_pre_out;
        else if (o_ctrl.inc)
            upc_d = upc_q + M2_ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            upc_q <= '0;
        else
            upc_q <= upc_d;
    end

endmodule

`default_nettype wire

// File: rtl/m2_cpu8.sv
//============================================================================
// Module   : m2_cpu8
// Brief    : SAP-1 class CPU: bus-based datapath and built-in program RAM
//            driven by a vertical microprogrammed sequencer.
// Config   : M2_CPU8_HLT_EN enables a true halt for the HLT opcode.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module m2_cpu8
    import m2_cpu8_pkg::*;
#(
    parameter int ADDR_W = M2_ADDR_W,
    parameter int OPC_W  = M2_OPC_W,
    parameter int DATA_W = M2_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              EP,
    output logic              CP,
    output logic              LM,
    output logic              CE_o,
    output logic              LI_o,
    output logic              EI_o,
    output logic              CS_o,
    output logic              LOAD_o,
    output logic              INC_o,
    output logic              CLR_o,
    output logic              LA_o,
    output logic              EA_o,
    output logic              SU_o,
    output logic              AD_o,
    output logic              EU_o,
    output logic              LB_o,
    output logic              LO_o,
    output logic [ADDR_W-1:0] PC_OUT_o,
    output logic [ADDR_W-1:0] SRAM_ADDR_o,
    output logic [OPC_W-1:0]  IR_1_OUT_o,
    output logic [ADDR_W-1:0] IR_2_OUT_o,
    output logic [DATA_W-1:0] SRAM_OUT,
    output logic [ADDR_W-1:0] PRE_OUT_o,
    output logic [DATA_W-1:0] ACC_OUT_o,
    output logic [DATA_W-1:0] ACC_OUT_bus_o,
    output logic [DATA_W-1:0] B_o,
    output logic [DATA_W-1:0] ALU_OUT_o,
    output logic [DATA_W-1:0] ALU_OUT_bus,
    output logic [DATA_W-1:0] OUT_o
);

    ctrl_t             ctrl;
    logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
    logic [DATA_W-1:0] bus, alu, sram_rd;

    m2_cpu8_useq u_useq (
        .clk       (clk),
        .rst       (rst),
        .i_opcode  (ir_q[DATA_W-1:ADDR_W]),
        .o_pre_out (PRE_OUT_o),
        .o_ctrl    (ctrl)
    );

    // Program memory is read-only in this instruction set, so it reduces to a lookup.
    assign sram_rd = ram_word(mar_q);
    assign alu     = ctrl.su ? (a_q - b_q) : (a_q + b_q);

    always_comb begin
        bus = '0;
        if (ctrl.ep) bus = bus | DATA_W'(pc_q);
        if (ctrl.ce) bus = bus | sram_rd;
        if (ctrl.ei) bus = bus | DATA_W'(ir_q[ADDR_W-1:0]);
        if (ctrl.ea) bus = bus | a_q;
        if (ctrl.eu) bus = bus | alu;
    end

    always_comb begin
        pc_d  = ctrl.cp ? pc_q + ADDR_W'(1) : pc_q;
        mar_d = ctrl.lm ? bus[ADDR_W-1:0]   : mar_q;
        ir_d  = ctrl.li ? bus : ir_q;
        a_d   = ctrl.la ? bus : a_q;
        b_d   = ctrl.lb ? bus : b_q;
        out_d = ctrl.lo ? bus : out_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= '0;
            mar_q <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            out_q <= '0;
        end else begin
            pc_q  <= pc_d;
            mar_q <= mar_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            out_q <= out_d;
        end
    end

    assign EP     = ctrl.ep;
    assign CP     = ctrl.cp;
    assign LM     = ctrl.lm;
    assign CE_o   = ctrl.ce;
    assign LI_o   = ctrl.li;
    assign EI_o   = ctrl.ei;
    assign CS_o   = ctrl.cs;
    assign LOAD_o = ctrl.load;
    assign INC_o  = ctrl.inc;
    assign CLR_o  = ctrl.clr;
    assign LA_o   = ctrl.la;
    assign EA_o   = ctrl.ea;
    assign SU_o   = ctrl.su;
    assign AD_o   = ctrl.ad;
    assign EU_o   = ctrl.eu;
    assign LB_o   = ctrl.lb;
    assign LO_o   = ctrl.lo;

    assign PC_OUT_o      = pc_q;
    assign SRAM_ADDR_o   = mar_q;
    assign IR_1_OUT_o    = ir_q[DATA_W-1:ADDR_W];
    assign IR_2_OUT_o    = ir_q[ADDR_W-1:0];
    assign SRAM_OUT      = sram_rd;
    assign ACC_OUT_o     = a_q;
    assign ACC_OUT_bus_o = ctrl.ea ? a_q : '0;
    assign B_o           = b_q;
    assign ALU_OUT_o     = alu;
    assign ALU_OUT_bus   = ctrl.eu ? alu : '0;
    assign OUT_o         = out_q;

endmodule

`default_nettype wire

// File: tb/tb_m2_cpu8.sv
//============================================================================
// Module   : tb_m2_cpu8
// Brief    : Scoreboard bench running the built-in program through m2_cpu8.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_m2_cpu8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       EP, CP, LM, CE_o, LI_o, EI_o, CS_o, LOAD_o, INC_o, CLR_o;
    logic       LA_o, EA_o, SU_o, AD_o, EU_o, LB_o, LO_o;
    logic [4:0] PC_OUT_o, SRAM_ADDR_o, IR_2_OUT_o, PRE_OUT_o;
    logic [3:0] IR_1_OUT_o;
    logic [8:0] SRAM_OUT, ACC_OUT_o, ACC_OUT_bus_o, B_o, ALU_OUT_o, ALU_OUT_bus, OUT_o;

    int checks = 0;
    int errors = 0;

    string       name_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] act_q[$];

    m2_cpu8 dut (
        .clk(clk), .rst(rst),
        .EP(EP), .CP(CP), .LM(LM), .CE_o(CE_o), .LI_o(LI_o), .EI_o(EI_o),
        .CS_o(CS_o), .LOAD_o(LOAD_o), .INC_o(INC_o), .CLR_o(CLR_o),
        .LA_o(LA_o), .EA_o(EA_o), .SU_o(SU_o), .AD_o(AD_o), .EU_o(EU_o),
        .LB_o(LB_o), .LO_o(LO_o),
        .PC_OUT_o(PC_OUT_o), .SRAM_ADDR_o(SRAM_ADDR_o), .IR_1_OUT_o(IR_1_OUT_o),
        .IR_2_OUT_o(IR_2_OUT_o), .SRAM_OUT(SRAM_OUT), .PRE_OUT_o(PRE_OUT_o),
        .ACC_OUT_o(ACC_OUT_o), .ACC_OUT_bus_o(ACC_OUT_bus_o), .B_o(B_o),
        .ALU_OUT_o(ALU_OUT_o), .ALU_OUT_bus(ALU_OUT_bus), .OUT_o(OUT_o)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_val(input string n, input logic [15:0] v);
        name_q.push_back(n);
        exp_q.push_back(v);
    endtask

    task automatic test_reset();
        string n; logic [15:0] e, a;
        expect_val("rst_pc", 0);   expect_val("rst_mar", 0);  expect_val("rst_ir_opc", 0);
        expect_val("rst_ir_opr", 0); expect_val("rst_a", 0);  expect_val("rst_b", 0);
        expect_val("rst_out", 0);  expect_val("rst_ep", 1);   expect_val("rst_lm", 1);
        expect_val("rst_cs", 1);   expect_val("lda_a", 16);   expect_val("lda_pc", 1);
        rst = 1'b1;
        #2 rst = 1'b0;
        step(2);
        act_q.push_back(16'(PC_OUT_o));  act_q.push_back(16'(SRAM_ADDR_o));
        act_q.push_back(16'(IR_1_OUT_o)); act_q.push_back(16'(IR_2_OUT_o));
        act_q.push_back(16'(ACC_OUT_o)); act_q.push_back(16'(B_o));
        act_q.push_back(16'(OUT_o));     act_q.push_back(16'(EP));
        act_q.push_back(16'(LM));        act_q.push_back(16'(CS_o));
        rst = 1'b1;
        step(6);
        act_q.push_back(16'(ACC_OUT_o)); act_q.push_back(16'(PC_OUT_o));
        while (exp_q.size() != 0) begin
            n = name_q.pop_front(); e = exp_q.pop_front();
            a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
        end
    endtask

    task automatic test_add();
        string n; logic [15:0] e, a;
        expect_val("add_alu_bus", 36); expect_val("add_eu", 1); expect_val("add_ad", 1);
        expect_val("add_b", 20);       expect_val("add_a", 36); expect_val("add_pc", 2);
        step(6);
        act_q.push_back(16'(ALU_OUT_bus)); act_q.push_back(16'(EU_o));
        act_q.push_back(16'(AD_o));        act_q.push_back(16'(B_o));
        step(1);
        act_q.push_back(16'(ACC_OUT_o));   act_q.push_back(16'(PC_OUT_o));
        while (exp_q.size() != 0) begin
            n = name_q.pop_front(); e = exp_q.pop_front();
            a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
        end
    endtask

    task automatic test_sub();
        string n; logic [15:0] e, a; logic [6:0] su_seen;
        expect_val("sub_su_steps", 16'b1000000); expect_val("sub_a", 30);
        expect_val("sub_b", 6);                   expect_val("sub_pc", 3);
        su_seen = '0;
        for (int i = 0; i < 7; i++) begin
            su_seen[i] = SU_o;
            step(1);
        end
        act_q.push_back(16'(su_seen)); act_q.push_back(16'(ACC_OUT_o));
        act_q.push_back(16'(B_o));     act_q.push_back(16'(PC_OUT_o));
        while (exp_q.size() != 0) begin
            n = name_q.pop_front(); e = exp_q.pop_front();
            a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
        end
    endtask

    task automatic test_out();
        string n; logic [15:0] e, a;
        expect_val("out_accbus_idle", 0); expect_val("out_ea", 1); expect_val("out_accbus", 30);
        expect_val("out_reg", 30);        expect_val("out_pc", 4);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) act_q.push_back(16'(ACC_OUT_bus_o));
            if (i == 4) begin
                act_q.push_back(16'(EA_o));
                act_q.push_back(16'(ACC_OUT_bus_o));
            end
            step(1);
        end
        act_q.push_back(16'(OUT_o)); act_q.push_back(16'(PC_OUT_o));
        while (exp_q.size() != 0) begin
            n = name_q.pop_front(); e = exp_q.pop_front();
            a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
        end
    endtask

    task automatic test_hlt();
        string n; logic [15:0] e, a;
        expect_val("hlt_fetch_pc", 5);
`ifdef M2_CPU8_HLT_EN
        expect_val("hlt_pc_after", 5);
        expect_val("hlt_cs", 0);
        expect_val("hlt_strobes", 16'h0000);
`else
        // HLT acts as NOP; the next fetch reads word 5 (an LDA 0) and advances to PC=7.
        expect_val("hlt_pc_after", 7);
        expect_val("hlt_cs", 1);
        expect_val("hlt_strobes", 16'h0200);
`endif
        step(4);
        act_q.push_back(16'(PC_OUT_o));
        step(10);
        act_q.push_back(16'(PC_OUT_o));
        act_q.push_back(16'(CS_o));
        act_q.push_back({EP, CP, LM, CE_o, LI_o, EI_o, LOAD_o, INC_o,
                         CLR_o, LA_o, EA_o, SU_o, AD_o, EU_o, LB_o, LO_o});
        while (exp_q.size() != 0) begin
            n = name_q.pop_front(); e = exp_q.pop_front();
            a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
        end
    endtask

    task automatic test_mid_reset();
        string n; logic [15:0] e, a;
        expect_val("mid_lb", 1);   expect_val("mid_ce", 1);   expect_val("mid_a_before", 16);
        expect_val("mid_pc_before", 2);
        expect_val("mid_a_clr", 0); expect_val("mid_pc_clr", 0); expect_val("mid_mar_clr", 0);
        expect_val("mid_ep", 1);
        expect_val("rerun_out", 30); expect_val("rerun_a", 30);
        rst = 1'b0;
        #2 rst = 1'b1;
        step(11);
        act_q.push_back(16'(LB_o)); act_q.push_back(16'(CE_o));
        act_q.push_back(16'(ACC_OUT_o)); act_q.push_back(16'(PC_OUT_o));
        #2 rst = 1'b0;
        #1;
        act_q.push_back(16'(ACC_OUT_o)); act_q.push_back(16'(PC_OUT_o));
        act_q.push_back(16'(SRAM_ADDR_o)); act_q.push_back(16'(EP));
        rst = 1'b1;
        step(25);
        act_q.push_back(16'(OUT_o)); act_q.push_back(16'(ACC_OUT_o));
        while (exp_q.size() != 0) begin
            n = name_q.pop_front(); e = exp_q.pop_front();
            a = (act_q.size() != 0) ? act_q.pop_front() : 16'hxxxx;
            checks++;
            if (a !== e) begin errors++; $display("FAIL %s: got %0d expected %0d", n, a, e); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_out();
        test_hlt();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/m2_cpu8.md
Name: m2_cpu8

Overview:
SAP-1 class 8-instruction-slot CPU with a vertical microprogrammed control unit.
- Datapath: 9-bit data, 5-bit addresses, internal 9-bit bus, 32x9 unified program/data RAM with a built-in program.
- Microsequencer: a micro-PC indexes a 32-word control store. Encoded micro-words are decoded into one-hot control strobes, all exported for debug.

Parameters:
- ADDR_W, 5, address width (PC, MAR, IR operand, micro-PC).
- OPC_W, 4, opcode width.
- DATA_W, 9, data/instruction width; must equal OPC_W+ADDR_W.

Ports:
- clk in 1: rising-edge clock.
- rst in 1: asynchronous, active-low reset.
- Control strobes, all out 1: EP, CP, LM, CE_o, LI_o, EI_o, CS_o, LOAD_o, INC_o, CLR_o, LA_o, EA_o, SU_o, AD_o, EU_o, LB_o, LO_o. Each is the decoded control signal named below.
- PC_OUT_o out 5: program counter.
- SRAM_ADDR_o out 5: MAR.
- IR_1_OUT_o out 4: IR opcode field, bits 8:5.
- IR_2_OUT_o out 5: IR operand field, bits 4:0.
- SRAM_OUT out 9: RAM[MAR].
- PRE_OUT_o out 5: mapping-ROM start address for the current opcode.
- ACC_OUT_o out 9: accumulator A.
- ACC_OUT_bus_o out 9: A when EA, else 0.
- B_o out 9: B register.
- ALU_OUT_o out 9: A+B, or A-B when SU.
- ALU_OUT_bus out 9: ALU_OUT_o when EU, else 0.
- OUT_o out 9: output register.

Behaviour:
- Reset (rst=0, async): PC, MAR, IR, A, B, OUT and micro-PC all go to 0. RAM contents are preserved.
- Bus: OR of the enabled sources, each zero-extended:
  - EP drives PC.
  - CE drives SRAM_OUT.
  - EI drives IR operand.
  - EA drives A.
  - EU drives ALU.
  - The microprogram never enables two sources in the same step.
- Register loads on the rising edge when the strobe is high:
  - LM: MAR <= bus[4:0].
  - LI: IR <= bus.
  - LA: A <= bus.
  - LB: B <= bus.
  - LO: OUT <= bus.
  - CP: PC <= PC+1, wrapping 31 to 0.
- Arithmetic: 9-bit modulo, no flags; 0-1 = 9'h1FF.
- Strobes are combinational decodes of the registered micro-PC, so after reset EP=LM=1 immediately.
- CS_o=1 whenever the control store is being sequenced; it is 0 only in the halt state.
- Micro-PC next-state:
  - CLR: 0.
  - LOAD: PRE_OUT_o.
  - INC: +1.
  - None of these: hold.
- Opcodes and mapping-ROM start addresses:
  - LDA 0000 -> 4.
  - ADD 0001 -> 6.
  - SUB 0010 -> 9.
  - OUT 1110 -> 12.
  - HLT 1111 -> 13.
  - Any other opcode -> 0 (NOP).
- Microprogram:
  - 0: EP LM INC.
  - 1: CP INC.
  - 2: CE LI INC.
  - 3: LOAD.
  - 4: EI LM INC.
  - 5: CE LA CLR.
  - 6: EI LM INC.
  - 7: CE LB INC.
  - 8: AD EU LA CLR.
  - 9: EI LM INC.
  - 10: CE LB INC.
  - 11: SU EU LA CLR.
  - 12: EA LO CLR.
  - 13: HLT state (see Optional Feature).
  - 14-31: CLR.
- Instruction lengths in clocks: LDA 6, ADD 7, SUB 7, OUT 5, NOP 4.
- Initial RAM contents, all other words 0:
  - 0 = LDA 9
  - 1 = ADD 10
  - 2 = SUB 11
  - 3 = OUT
  - 4 = HLT
  - 9 = 16
  - 10 = 20
  - 11 = 6
- Reset asserted mid-instruction aborts the instruction; execution restarts at the fetch step with PC=0.

Optional Feature:
- Macro M2_CPU8_HLT_EN.
- Defined: micro-word 13 issues no INC/LOAD/CLR, so the micro-PC holds at 13 with CS_o=0 and all strobes 0 until reset.
- Undefined: micro-word 13 issues CLR, so HLT behaves as NOP and execution continues at PC+1.

Decomposition:
- Package m2_cpu8_pkg holds:
  - Width constants.
  - Opcode constants.
  - Micro-op encoding enum.
  - Mapping-ROM start addresses.
- Sub-module m2_cpu8_useq contains the micro-PC, mapping ROM, control store and strobe decoder. The top level contains the datapath and RAM.

Test Plan:
- Reset: hold rst=0 -> all registers 0, EP=LM=CS_o=1. Release reset -> after the 6-clock LDA, A=16 and PC=1.
- ADD: continue 7 clocks -> B=20, A=36, PC=2. During the last step ALU_OUT_bus=36 and EU=AD=1.
- SUB: continue 7 clocks -> B=6, A=30; SU_o=1 only in micro-step 11.
- OUT: continue 5 clocks -> OUT_o=30 and ACC_OUT_bus_o=30 during EA. Then the HLT fetch occurs.
- HLT: with M2_CPU8_HLT_EN, CS_o=0 and the PC frozen at 5 over 10 clocks. Without it, the PC keeps advancing.
- Mid-instruction reset: assert rst during ADD micro-step 7 -> registers clear asynchronously and the program reruns, reaching OUT_o=30 again.
